// File: rtl/tun_interp.sv
// Tuning engine: MIDI note + fractional semitone -> waveguide delay length.
// One single-octave table, linear interpolation, then one right shift per octave.
module tun_interp #(
    parameter int LEN_W   = 11,
    parameter int FRAC_W  = 8,
    parameter int NOTE_LO = 24,
    parameter int MIN_LEN = 4,
    parameter int TAG_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [6:0]        note,
    input  logic [FRAC_W-1:0] frac,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              busy,
    output logic              out_valid,
    output logic [LEN_W-1:0]  len_out,
    output logic [TAG_W-1:0]  tag_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam int         P_W       = LEN_W + FRAC_W;
    localparam logic [6:0] NOTE_LO_N = 7'(NOTE_LO);
    localparam logic [LEN_W-1:0] MIN_LEN_N = LEN_W'(MIN_LEN);

    // One octave of delay lengths, scaled up for wider outputs.
    function automatic logic [LEN_W-1:0] tbl(input logic [3:0] idx);
        logic [10:0] v;
        case (idx)
            4'd0:    v = 11'd2047;
            4'd1:    v = 11'd1932;
            4'd2:    v = 11'd1824;
            4'd3:    v = 11'd1721;
            4'd4:    v = 11'd1625;
            4'd5:    v = 11'd1534;
            4'd6:    v = 11'd1447;
            4'd7:    v = 11'd1366;
            4'd8:    v = 11'd1290;
            4'd9:    v = 11'd1217;
            4'd10:   v = 11'd1149;
            4'd11:   v = 11'd1084;
            default: v = 11'd1024;
        endcase
        return LEN_W'(v) << (LEN_W - 11);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [6:0]        rem_q, rem_d;
    logic [3:0]        oct_q, oct_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [LEN_W-1:0]  a_q, a_d;
    logic [LEN_W-1:0]  d_q, d_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;
    logic              valid_q, valid_d;
    logic [LEN_W-1:0]  diff;
    logic [LEN_W-1:0]  shifted;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        rem_d     = rem_q;
        oct_d     = oct_q;
        frac_d    = frac_q;
        tag_d     = tag_q;
        a_d       = a_q;
        d_d       = d_q;
        p_d       = p_q;
        len_d     = len_q;
        tag_out_d = tag_out_q;
        valid_d   = 1'b0;
        diff      = '0;
        shifted   = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    tag_d = tag_in;
                    oct_d = '0;
                    // Notes below the table range clamp to its bottom with no bend.
                    if (note < NOTE_LO_N) begin
                        rem_d  = '0;
                        frac_d = '0;
                    end else begin
                        rem_d  = note - NOTE_LO_N;
                        frac_d = frac;
                    end
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_q >= 7'd12) begin
                    rem_d = rem_q - 7'd12;
                    oct_d = oct_q + 4'd1;
                end else begin
                    a_d     = tbl(rem_q[3:0]);
                    d_d     = tbl(rem_q[3:0]) - tbl(rem_q[3:0] + 4'd1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p_d     = P_W'(d_q) * P_W'(frac_q);
                state_d = S_INT;
            end
            S_INT: begin
                // p >> FRAC_W is always below d <= a, so the subtraction cannot wrap.
                diff      = a_q - p_q[P_W-1:FRAC_W];
                shifted   = diff >> oct_q;
                len_d     = (shifted < MIN_LEN_N) ? MIN_LEN_N : shifted;
                tag_out_d = tag_q;
                valid_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            oct_q     <= '0;
            frac_q    <= '0;
            tag_q     <= '0;
            a_q       <= '0;
            d_q       <= '0;
            p_q       <= '0;
            len_q     <= '0;
            tag_out_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            oct_q     <= oct_d;
            frac_q    <= frac_d;
            tag_q     <= tag_d;
            a_q       <= a_d;
            d_q       <= d_d;
            p_q       <= p_d;
            len_q     <= len_d;
            tag_out_q <= tag_out_d;
            valid_q   <= valid_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = valid_q;
    assign len_out   = len_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_tun_interp.sv
// Self-checking bench for tun_interp: directed and random conversions against an
// arithmetic reference model, handshake streaming, reset abort, and parameter variants.
module tb_tun_interp;

    localparam int NOTE_LO = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Default-parameter instance
    logic        req, busy, out_valid;
    logic [6:0]  note;
    logic [7:0]  frac;
    logic [2:0]  tag_in, tag_out;
    logic [10:0] len_out;

    // LEN_W=13, FRAC_W=4 instance
    logic        b_req, b_busy, b_valid;
    logic [6:0]  b_note;
    logic [3:0]  b_frac;
    logic [2:0]  b_tag, b_tag_out;
    logic [12:0] b_len;

    // MIN_LEN=8 instance
    logic        c_req, c_busy, c_valid;
    logic [6:0]  c_note;
    logic [7:0]  c_frac;
    logic [2:0]  c_tag, c_tag_out;
    logic [10:0] c_len;

    tun_interp dut (
        .clk(clk), .rst_n(rst_n), .req(req), .note(note), .frac(frac), .tag_in(tag_in),
        .busy(busy), .out_valid(out_valid), .len_out(len_out), .tag_out(tag_out)
    );

    tun_interp #(.LEN_W(13), .FRAC_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .note(b_note), .frac(b_frac), .tag_in(b_tag),
        .busy(b_busy), .out_valid(b_valid), .len_out(b_len), .tag_out(b_tag_out)
    );

    tun_interp #(.MIN_LEN(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(c_req), .note(c_note), .frac(c_frac), .tag_in(c_tag),
        .busy(c_busy), .out_valid(c_valid), .len_out(c_len), .tag_out(c_tag_out)
    );

    int checks = 0;
    int errors = 0;

    int tbl_v[13] = '{2047, 1932, 1824, 1721, 1625, 1534, 1447, 1366, 1290, 1217, 1149, 1084, 1024};

    longint q_len[$];
    int     q_tag[$];
    int     q_due[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Reference: octave/semitone split by division, then interpolate and shift.
    function automatic longint ref_len(int n_in, int f_in, int len_w, int frac_w, int min_len);
        int     n, rem, oct;
        longint f, a, d, l;
        n   = (n_in < NOTE_LO) ? NOTE_LO : n_in;
        f   = (n_in < NOTE_LO) ? 0 : f_in;
        rem = (n - NOTE_LO) % 12;
        oct = (n - NOTE_LO) / 12;
        a   = longint'(tbl_v[rem]) << (len_w - 11);
        d   = longint'(tbl_v[rem] - tbl_v[rem+1]) << (len_w - 11);
        l   = (a - ((d * f) >> frac_w)) >> oct;
        return (l < min_len) ? min_len : l;
    endfunction

    function automatic int ref_lat(int n_in);
        int n;
        n = (n_in < NOTE_LO) ? NOTE_LO : n_in;
        return (n - NOTE_LO) / 12 + 3;
    endfunction

    task automatic conv_a(input int n, input int f, input int t, input string name);
        int     k;
        bit     seen;
        longint exp_len;
        exp_len = ref_len(n, f, 11, 8, 4);
        @(negedge clk);
        for (int w = 0; w < 40 && busy; w++) @(negedge clk);
        req = 1'b1; note = 7'(n); frac = 8'(f); tag_in = 3'(t);
        @(posedge clk);
        #1;
        req = 1'b0; note = 7'($urandom); frac = 8'($urandom); tag_in = 3'($urandom);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({name, " latency"}, seen ? k : -1, ref_lat(n));
        check({name, " len"}, len_out, exp_len);
        check({name, " tag"}, tag_out, t);
        @(negedge clk);
        check({name, " pulse"}, out_valid, 0);
        check({name, " hold"}, len_out, exp_len);
    endtask

    task automatic conv_side(input bit use_c, input int n, input int f, input int t, input string name);
        int     k;
        bit     seen;
        longint exp_len;
        exp_len = use_c ? ref_len(n, f, 11, 8, 8) : ref_len(n, f, 13, 4, 4);
        @(negedge clk);
        for (int w = 0; w < 40 && (use_c ? c_busy : b_busy); w++) @(negedge clk);
        if (use_c) begin
            c_req = 1'b1; c_note = 7'(n); c_frac = 8'(f); c_tag = 3'(t);
        end else begin
            b_req = 1'b1; b_note = 7'(n); b_frac = 4'(f); b_tag = 3'(t);
        end
        @(posedge clk);
        #1;
        b_req = 1'b0;
        c_req = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (use_c ? c_valid : b_valid) seen = 1'b1;
        end
        check({name, " latency"}, seen ? k : -1, ref_lat(n));
        check({name, " len"}, use_c ? 64'(c_len) : 64'(b_len), exp_len);
        check({name, " tag"}, use_c ? c_tag_out : b_tag_out, t);
    endtask

    initial begin
        int  n, f, t;
        bit  was_busy, exp_v, seen;

        rst_n = 1'b0;
        req = 1'b1; note = 7'd60; frac = 8'd0; tag_in = 3'd5;
        b_req = 1'b0; b_note = '0; b_frac = '0; b_tag = '0;
        c_req = 1'b0; c_note = '0; c_frac = '0; c_tag = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset len_out", len_out, 0);
        check("reset tag_out", tag_out, 0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        conv_a(24, 0, 0, "table n24");
        conv_a(30, 0, 1, "table n30");
        conv_a(36, 0, 2, "table n36");
        conv_a(24, 128, 3, "interp n24");
        conv_a(35, 255, 4, "interp n35");
        conv_a(127, 0, 5, "top n127");
        conv_a(10, 200, 6, "clamp n10");
        conv_a(23, 255, 7, "clamp n23");
        repeat (30) begin
            conv_a($urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 7), "random");
        end

        // Streaming: req held high, a fresh request every cycle; only idle-edge ones are served.
        @(negedge clk);
        for (int c = 0; c < 300; c++) begin
            n = $urandom_range(0, 127);
            f = $urandom_range(0, 255);
            t = $urandom_range(0, 7);
            req = 1'b1; note = 7'(n); frac = 8'(f); tag_in = 3'(t);
            was_busy = busy;
            @(posedge clk);
            if (!was_busy) begin
                q_len.push_back(ref_len(n, f, 11, 8, 4));
                q_tag.push_back(t);
                q_due.push_back(c + ref_lat(n));
            end
            @(negedge clk);
            exp_v = (q_due.size() > 0) && (q_due[0] == c);
            check("stream valid", out_valid, exp_v);
            if (exp_v) begin
                check("stream len", len_out, q_len.pop_front());
                check("stream tag", tag_out, q_tag.pop_front());
                void'(q_due.pop_front());
            end
        end
        req = 1'b0;
        for (int w = 0; w < 20 && busy; w++) @(negedge clk);

        // Abort a conversion two cycles in.
        @(negedge clk);
        req = 1'b1; note = 7'd127; frac = 8'd0; tag_in = 3'd1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort no result", seen, 0);
        check("abort len_out", len_out, 0);
        check("abort busy after", busy, 0);

        conv_side(1'b0, 24, 0, 2, "wide n24");
        conv_side(1'b0, 24, 8, 3, "wide n24 f8");
        conv_side(1'b0, $urandom_range(24, 127), $urandom_range(0, 15), 4, "wide random");
        conv_side(1'b1, 127, 0, 6, "minlen n127");
        conv_side(1'b1, 24, 0, 7, "minlen n24");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
